// File: rtl/traffic_ctrl_param_if.sv
// Purpose : control/status bundle between the intersection top level and traffic_ctrl_param.
// Latency : wires only; all outputs are registered inside the controller.
// Backpres: none; inputs are sampled every clk, and outputs are always valid.
// Ports   : i_start/i_ped_req/i_flash (to controller); o_car_traffic, o_walker_traffic,
//           o_phase, o_remain, o_ped_pending (from controller).
interface traffic_ctrl_param_if #(
    parameter int TIMER_W = 8
);
    logic               i_start;
    logic               i_ped_req;
    logic               i_flash;
    logic [3:0]         o_car_traffic;
    logic [1:0]         o_walker_traffic;
    logic [3:0]         o_phase;
    logic [TIMER_W-1:0] o_remain;
    logic               o_ped_pending;

    // Top-level side: drives the requests and observes the lamps and status.
    modport master (
        output i_start, i_ped_req, i_flash,
        input  o_car_traffic, o_walker_traffic, o_phase, o_remain, o_ped_pending
    );

    // Controller side.
    modport slave (
        input  i_start, i_ped_req, i_flash,
        output o_car_traffic, o_walker_traffic, o_phase, o_remain, o_ped_pending
    );
endinterface

// File: rtl/traffic_ctrl_param.sv
// Purpose : parametrised intersection controller (car head + pedestrian head), Moore FSM.
// Latency : inputs take effect at the next clk edge; outputs decode registered state only.
// Backpres: none; requests are sampled every cycle, and a ped request is latched until served.
// Ports   : clk, reset_n (async, active-low), bus (slave side of traffic_ctrl_param_if).
module traffic_ctrl_param #(
    parameter int TIMER_W       = 8,
    parameter int T_GREEN       = 20,
    parameter int T_GREEN_MIN   = 8,
    parameter int T_YEL         = 2,
    parameter int T_LEFT        = 10,
    parameter int T_WALK        = 14,
    parameter int T_BLINK       = 6,
    parameter int T_CLEAR       = 14,
    parameter int BLINK_HALF    = 1,
    parameter int FLASH_HALF    = 4,
    parameter bit PED_ON_DEMAND = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    traffic_ctrl_param_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_GREEN = 4'd1,
        S_YEL1  = 4'd2,
        S_LEFT  = 4'd3,
        S_YEL2  = 4'd4,
        S_WALK  = 4'd5,
        S_BLINK = 4'd6,
        S_CLEAR = 4'd7,
        S_FLASH = 4'd8
    } state_t;

    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);

    localparam logic [TIMER_W-1:0] LD_GREEN = TIMER_W'(T_GREEN - 1);
    localparam logic [TIMER_W-1:0] LD_YEL   = TIMER_W'(T_YEL - 1);
    localparam logic [TIMER_W-1:0] LD_LEFT  = TIMER_W'(T_LEFT - 1);
    localparam logic [TIMER_W-1:0] LD_WALK  = TIMER_W'(T_WALK - 1);
    localparam logic [TIMER_W-1:0] LD_BLINK = TIMER_W'(T_BLINK - 1);
    localparam logic [TIMER_W-1:0] LD_CLEAR = TIMER_W'(T_CLEAR - 1);
    // Timer counts down from T_GREEN-1, so timer <= this means at least T_GREEN_MIN green cycles.
    localparam logic [TIMER_W-1:0] EARLY_TH = TIMER_W'(T_GREEN - T_GREEN_MIN);

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer, load_val;
    logic               ped_pending;
    logic               blink_bit, flash_bit;
    logic [BW-1:0]      blink_cnt;
    logic [FW-1:0]      flash_cnt;
    logic               t_last;
    logic               entering;

    assign t_last   = (timer == '0);
    assign entering = (state_nxt != state);

    // Next-state: stop beats flash, and flash beats the normal sequence.
    always_comb begin
        state_nxt = state;
        if (!bus.i_start) begin
            state_nxt = S_IDLE;
        end else if (bus.i_flash) begin
            state_nxt = S_FLASH;
        end else begin
            unique case (state)
                S_IDLE:  state_nxt = S_GREEN;
                S_GREEN: if (t_last || (ped_pending && timer <= EARLY_TH)) state_nxt = S_YEL1;
                S_YEL1:  if (t_last) state_nxt = S_LEFT;
                S_LEFT:  if (t_last) state_nxt = S_YEL2;
                S_YEL2:  if (t_last) state_nxt = (PED_ON_DEMAND && !ped_pending) ? S_CLEAR : S_WALK;
                S_WALK:  if (t_last) state_nxt = S_BLINK;
                S_BLINK: if (t_last) state_nxt = S_CLEAR;
                S_CLEAR: if (t_last) state_nxt = S_GREEN;
                S_FLASH: state_nxt = S_CLEAR;  // leaving night mode always clears the box first
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        load_val = '0;
        unique case (state_nxt)
            S_GREEN:        load_val = LD_GREEN;
            S_YEL1, S_YEL2: load_val = LD_YEL;
            S_LEFT:         load_val = LD_LEFT;
            S_WALK:         load_val = LD_WALK;
            S_BLINK:        load_val = LD_BLINK;
            S_CLEAR:        load_val = LD_CLEAR;
            default:        load_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            ped_pending <= 1'b0;
            blink_bit   <= 1'b0;
            blink_cnt   <= '0;
            flash_bit   <= 1'b0;
            flash_cnt   <= '0;
        end else begin
            state <= state_nxt;

            if (entering)          timer <= load_val;
            else if (timer != '0)  timer <= timer - TIMER_W'(1);

            // Entering WALK serves the request and wins over a same-cycle press.
            if ((entering && state_nxt == S_WALK) ||
                state_nxt == S_IDLE || state_nxt == S_FLASH ||
                state == S_IDLE || state == S_FLASH)
                ped_pending <= 1'b0;
            else if (bus.i_ped_req && state != S_WALK && state != S_BLINK)
                ped_pending <= 1'b1;

            if (entering && state_nxt == S_BLINK) begin
                blink_bit <= 1'b0;
                blink_cnt <= '0;
            end else if (state == S_BLINK) begin
                if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                    blink_cnt <= '0;
                    blink_bit <= ~blink_bit;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end

            if (entering && state_nxt == S_FLASH) begin
                flash_bit <= 1'b0;
                flash_cnt <= '0;
            end else if (state == S_FLASH) begin
                if (flash_cnt == FW'(FLASH_HALF - 1)) begin
                    flash_cnt <= '0;
                    flash_bit <= ~flash_bit;
                end else begin
                    flash_cnt <= flash_cnt + FW'(1);
                end
            end
        end
    end

    // Lamp decode: car {red, yellow, left, green}, walker {red, green}.
    always_comb begin
        bus.o_car_traffic    = 4'b0000;
        bus.o_walker_traffic = 2'b00;
        bus.o_remain         = timer;
        unique case (state)
            S_GREEN:        begin bus.o_car_traffic = 4'b0001; bus.o_walker_traffic = 2'b10; end
            S_YEL1, S_YEL2: begin bus.o_car_traffic = 4'b0100; bus.o_walker_traffic = 2'b10; end
            S_LEFT:         begin bus.o_car_traffic = 4'b0010; bus.o_walker_traffic = 2'b10; end
            S_WALK:         begin bus.o_car_traffic = 4'b1000; bus.o_walker_traffic = 2'b01; end
            S_BLINK: begin
                bus.o_car_traffic    = 4'b1000;
                bus.o_walker_traffic = blink_bit ? 2'b00 : 2'b01;
            end
            S_CLEAR:        begin bus.o_car_traffic = 4'b1000; bus.o_walker_traffic = 2'b10; end
            S_FLASH: begin
                bus.o_car_traffic = flash_bit ? 4'b0000 : 4'b0100;
                bus.o_remain      = '0;
            end
            default:        bus.o_remain = '0;
        endcase
    end

    assign bus.o_phase       = state;
    assign bus.o_ped_pending = ped_pending;
endmodule

// File: tb/tb_traffic_ctrl_param.sv
module tb_traffic_ctrl_param;
    localparam int TG = 20, TGM = 8, TY = 2, TL = 10, TW = 14, TB = 6, TC = 14;
    localparam int BH = 1, FH = 4;
    localparam int P_IDLE = 0, P_GREEN = 1, P_YEL1 = 2, P_LEFT = 3, P_YEL2 = 4;
    localparam int P_WALK = 5, P_BLINK = 6, P_CLEAR = 7, P_FLASH = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic start, ped, flash;

    always #5 clk = ~clk;

    traffic_ctrl_param_if #(.TIMER_W(8)) ifa();
    traffic_ctrl_param_if #(.TIMER_W(8)) ifb();
    assign ifa.i_start = start;  assign ifa.i_ped_req = ped;  assign ifa.i_flash = flash;
    assign ifb.i_start = start;  assign ifb.i_ped_req = ped;  assign ifb.i_flash = flash;

    traffic_ctrl_param #(.PED_ON_DEMAND(1'b0)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
    traffic_ctrl_param #(.PED_ON_DEMAND(1'b1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

    // Reference model: phase, cycles already spent in it, latched request.
    typedef struct { int ph; int el; bit pend; } mdl_t;
    typedef struct packed {
        logic [3:0] car; logic [1:0] wlk; logic [3:0] ph; logic [7:0] rem; logic pend;
    } exp_t;

    mdl_t ma, mb;
    exp_t qa[$], qb[$];
    int checks = 0, errors = 0;
    int cyc = 0;
    int chk_per_a = 0, chk_per_b = 0, chk_glen_a = 0;
    int gs_a = -1, gs_b = -1;
    logic [3:0] prev_pa = 4'd0, prev_pb = 4'd0;

    function automatic int dur(int p);
        case (p)
            P_GREEN: return TG;
            P_YEL1, P_YEL2: return TY;
            P_LEFT: return TL;
            P_WALK: return TW;
            P_BLINK: return TB;
            P_CLEAR: return TC;
            default: return 0;
        endcase
    endfunction

    function automatic mdl_t mreset();
        mdl_t m;
        m.ph = P_IDLE; m.el = 0; m.pend = 1'b0;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, bit st, bit pr, bit fl, bit od);
        mdl_t n;
        bit last;
        int nx;
        last = (dur(m.ph) > 0) && (m.el == dur(m.ph) - 1);
        nx = m.ph;
        if (!st) nx = P_IDLE;
        else if (fl) nx = P_FLASH;
        else case (m.ph)
            P_IDLE:  nx = P_GREEN;
            P_GREEN: if (last || (m.pend && m.el + 1 >= TGM)) nx = P_YEL1;
            P_YEL1:  if (last) nx = P_LEFT;
            P_LEFT:  if (last) nx = P_YEL2;
            P_YEL2:  if (last) nx = (od && !m.pend) ? P_CLEAR : P_WALK;
            P_WALK:  if (last) nx = P_BLINK;
            P_BLINK: if (last) nx = P_CLEAR;
            P_CLEAR: if (last) nx = P_GREEN;
            P_FLASH: nx = P_CLEAR;
            default: nx = P_IDLE;
        endcase
        n.ph = nx;
        n.el = (nx != m.ph) ? 0 : m.el + 1;
        if (nx == P_IDLE || nx == P_FLASH || m.ph == P_IDLE || m.ph == P_FLASH ||
            (nx == P_WALK && m.ph != P_WALK))
            n.pend = 1'b0;
        else
            n.pend = m.pend | (pr && m.ph != P_WALK && m.ph != P_BLINK);
        return n;
    endfunction

    function automatic exp_t outs(mdl_t m);
        exp_t e;
        e.car = 4'b0000; e.wlk = 2'b00;
        e.ph = 4'(m.ph); e.pend = m.pend;
        e.rem = (dur(m.ph) > 0) ? 8'(dur(m.ph) - 1 - m.el) : 8'd0;
        case (m.ph)
            P_GREEN: begin e.car = 4'b0001; e.wlk = 2'b10; end
            P_YEL1, P_YEL2: begin e.car = 4'b0100; e.wlk = 2'b10; end
            P_LEFT: begin e.car = 4'b0010; e.wlk = 2'b10; end
            P_WALK: begin e.car = 4'b1000; e.wlk = 2'b01; end
            P_BLINK: begin e.car = 4'b1000; e.wlk = ((m.el / BH) % 2 == 1) ? 2'b00 : 2'b01; end
            P_CLEAR: begin e.car = 4'b1000; e.wlk = 2'b10; end
            P_FLASH: e.car = ((m.el / FH) % 2 == 1) ? 4'b0000 : 4'b0100;
            default: ;
        endcase
        return e;
    endfunction

    // One clock of stimulus: advance both models with the inputs the DUTs sample at this edge.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            ma = mreset(); mb = mreset();
        end else begin
            ma = step(ma, start, ped, flash, 1'b0);
            mb = step(mb, start, ped, flash, 1'b1);
        end
        qa.push_back(outs(ma));
        qb.push_back(outs(mb));
        #1;
    endtask

    task automatic wait_a(int p, int e);
        for (int i = 0; i < 300; i++) begin
            if (ma.ph == p && ma.el == e) return;
            tick();
        end
        checks++; errors++;
        $display("FAIL wait_a phase %0d/%0d not reached within 300 cycles (now %0d/%0d)", p, e, ma.ph, ma.el);
    endtask

    task automatic wait_b(int p, int e);
        for (int i = 0; i < 300; i++) begin
            if (mb.ph == p && mb.el == e) return;
            tick();
        end
        checks++; errors++;
        $display("FAIL wait_b phase %0d/%0d not reached within 300 cycles (now %0d/%0d)", p, e, mb.ph, mb.el);
    endtask

    task automatic cmp(string nm, exp_t e, exp_t a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc %0d got car=%b wlk=%b ph=%0d rem=%0d pend=%b want car=%b wlk=%b ph=%0d rem=%0d pend=%b",
                     nm, cyc, a.car, a.wlk, a.ph, a.rem, a.pend, e.car, e.wlk, e.ph, e.rem, e.pend);
        end
    endtask

    // Monitor: outputs are always valid, so every negedge with a pending expectation is compared.
    always @(negedge clk) begin
        exp_t e, a;
        cyc++;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            a = {ifa.o_car_traffic, ifa.o_walker_traffic, ifa.o_phase, ifa.o_remain, ifa.o_ped_pending};
            cmp("dut_a", e, a);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            a = {ifb.o_car_traffic, ifb.o_walker_traffic, ifb.o_phase, ifb.o_remain, ifb.o_ped_pending};
            cmp("dut_b", e, a);
        end
        if (prev_pa == 4'd1 && ifa.o_phase != 4'd1 && chk_glen_a != 0 && gs_a >= 0) begin
            checks++;
            if (cyc - gs_a != chk_glen_a) begin
                errors++;
                $display("FAIL green_len_a got %0d want %0d", cyc - gs_a, chk_glen_a);
            end
        end
        if (ifa.o_phase == 4'd1 && prev_pa != 4'd1) begin
            if (chk_per_a != 0 && gs_a >= 0) begin
                checks++;
                if (cyc - gs_a != chk_per_a) begin
                    errors++;
                    $display("FAIL period_a got %0d want %0d", cyc - gs_a, chk_per_a);
                end
            end
            gs_a = cyc;
        end
        if (ifb.o_phase == 4'd1 && prev_pb != 4'd1) begin
            if (chk_per_b != 0 && gs_b >= 0) begin
                checks++;
                if (cyc - gs_b != chk_per_b) begin
                    errors++;
                    $display("FAIL period_b got %0d want %0d", cyc - gs_b, chk_per_b);
                end
            end
            gs_b = cyc;
        end
        prev_pa = ifa.o_phase;
        prev_pb = ifb.o_phase;
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; ped = 1'b0; flash = 1'b0;
        ma = mreset(); mb = mreset();
        repeat (3) tick();
        #1 reset_n = 1'b1;
        start = 1'b1;

        // Free run: fixed 68-cycle period, 48 when walk is on demand and never requested.
        chk_per_a = 68; chk_per_b = 48;
        repeat (150) tick();
        chk_per_a = 0; chk_per_b = 0;

        // Ped press in green cycle 2 cuts green to the minimum.
        wait_a(P_GREEN, 1);
        chk_glen_a = TGM;
        ped = 1'b1; tick(); ped = 1'b0;
        wait_a(P_WALK, 0);
        chk_glen_a = 0;

        // On-demand unit: press during LEFT brings WALK back into the cycle.
        wait_b(P_LEFT, 3);
        ped = 1'b1; tick(); ped = 1'b0;
        repeat (40) tick();

        // Night mode entered mid-LEFT, then released.
        wait_a(P_LEFT, 4);
        flash = 1'b1; repeat (20) tick();
        flash = 1'b0; repeat (40) tick();

        // Asynchronous reset mid-YEL1, checked before any further clock edge.
        wait_a(P_YEL1, 0);
        #2 reset_n = 1'b0;
        ma = mreset(); mb = mreset();
        qa.delete(); qb.delete();
        qa.push_back(outs(ma)); qb.push_back(outs(mb));
        repeat (2) tick();
        #1 reset_n = 1'b1;
        repeat (30) tick();

        // Stop during WALK, then restart into a full green.
        wait_a(P_WALK, 2);
        start = 1'b0; tick();
        start = 1'b1; repeat (40) tick();

        // Randomised run.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 149) == 0) flash = ~flash;
            ped = ($urandom_range(0, 9) == 0);
            tick();
        end
        ped = 1'b0; flash = 1'b0; start = 1'b1;
        repeat (3) tick();
        #10;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_ctrl_param.md
Name: traffic_ctrl_param

Overview:
- Parametrised successor to the fixed 68-cycle intersection controller. Drives one car signal head (one-hot red/yellow/left/green) and one pedestrian head (red/green, blinking green before clearance).
- Adds per-phase programmable durations, a pedestrian request with early green termination, an on-demand walk mode, a night flashing-yellow mode, and phase/remaining-time status outputs.
- Sits between the intersection top level and the lamp drivers. It is a Moore FSM with a single down-counting phase timer.

Parameters:
- TIMER_W, 8, width of phase timer and o_remain.
- T_GREEN, 20, car green cycles (max).
- T_GREEN_MIN, 8, minimum green cycles before a ped request may cut green short (1..T_GREEN).
- T_YEL, 2, cycles of each yellow phase.
- T_LEFT, 10, left-arrow cycles.
- T_WALK, 14, steady walker-green cycles.
- T_BLINK, 6, walker-blink cycles.
- T_CLEAR, 14, all-car-red / walker-red cycles.
- BLINK_HALF, 1, cycles per half-period of walker blink.
- FLASH_HALF, 4, cycles per half-period of night flashing yellow.
- PED_ON_DEMAND, 0, 1 = WALK/BLINK skipped when no request pending.
- All T_* must satisfy 1 <= T <= 2^TIMER_W.

Ports:
- clk, input, 1, system clock, rising edge.
- reset_n, input, 1, reset, asynchronous, active-low.
- i_start, input, 1, run enable; low forces IDLE.
- i_ped_req, input, 1, pedestrian button, level or pulse, sampled each clk.
- i_flash, input, 1, night mode request.
- o_car_traffic, output, 4, {red, yellow, left, green} one-hot; 4'b0000 = dark.
- o_walker_traffic, output, 2, {red, green}; 2'b00 = dark.
- o_phase, output, 4, current state code.
- o_remain, output, TIMER_W, phase timer value; 0 in the last cycle of a phase.
- o_ped_pending, output, 1, latched pedestrian request.

Behaviour:
- States and codes: IDLE=0, GREEN=1, YEL1=2, LEFT=3, YEL2=4, WALK=5, BLINK=6, CLEAR=7, FLASH=8.
- Outputs are decoded from registered state, timer and blink/flash bits only. There is no combinational path from inputs to outputs.
- Reset (async, reset_n=0): state=IDLE, timer=0, ped_pending=0, blink/flash bits=0.
  - Outputs during reset: car=0000, walker=00, o_phase=0, o_remain=0, o_ped_pending=0.
  - Reset mid-phase aborts immediately; no yellow is completed.
- Timer: loaded with T_x-1 on entry to phase x and decrements each cycle. The phase ends on the cycle timer==0; the next state's timer is loaded on that same edge. Phase x therefore lasts exactly T_x cycles.
- Next-state priority: i_start=0 -> IDLE; else i_flash=1 -> FLASH; else the normal sequence below.
- Normal sequence:
  - IDLE -> GREEN on the first cycle i_start=1.
  - GREEN -> YEL1 -> LEFT -> YEL2 -> WALK -> BLINK -> CLEAR -> GREEN.
  - Default period is 68 cycles.
- Early green: in GREEN, if ped_pending=1 and timer <= T_GREEN-T_GREEN_MIN, go to YEL1 at that edge. Green is never shorter than T_GREEN_MIN cycles.
- PED_ON_DEMAND=1: at the end of YEL2, go to WALK if ped_pending=1, else go directly to CLEAR. With PED_ON_DEMAND=0, WALK always follows YEL2.
- ped_pending:
  - Set on any cycle with i_ped_req=1 while state is not WALK or BLINK.
  - Cleared on the edge entering WALK; this clear takes priority over a same-cycle set.
  - Forced to 0 in IDLE and FLASH.
- Car decode:
  - GREEN = 0001.
  - YEL1 and YEL2 = 0100.
  - LEFT = 0010.
  - WALK, BLINK, CLEAR = 1000.
  - IDLE = 0000.
  - FLASH = 0100 while flash bit=0, 0000 while flash bit=1.
- Walker decode:
  - GREEN through YEL2, and CLEAR = 10.
  - WALK = 01.
  - BLINK = 01 while blink bit=0, 00 while blink bit=1.
  - IDLE and FLASH = 00.
- Blink bit: cleared on entry to BLINK, toggles every BLINK_HALF cycles.
- Flash bit: cleared on entry to FLASH, toggles every FLASH_HALF cycles. FLASH therefore starts with yellow on.
- Exit from FLASH when i_flash=0 goes to CLEAR, never directly to GREEN.
- o_remain = timer in all timed states; 0 in IDLE and FLASH.
- Simultaneous events:
  - i_start fall together with i_flash: IDLE wins.
  - i_flash rise during YEL or WALK: FLASH is entered at the next edge.

Test Plan:
- Defaults; reset released; i_start=1 held, no ped, no flash.
  - Required phase lengths: green 20, yellow 2, left 10, yellow 2, walk 14, blink 6 (walker 01,00,01,00,01,00), clear 14.
  - Green reappears exactly 68 cycles after the first green.
- Defaults; i_ped_req pulsed at green cycle 2 -> o_ped_pending=1 next cycle; green lasts 8 cycles; YEL1 starts in cycle 9; o_ped_pending drops on WALK entry.
- PED_ON_DEMAND=1, no request -> YEL2 followed directly by CLEAR; period 48 cycles. Then ped pulse during LEFT -> WALK is present in that cycle.
- i_flash=1 mid-LEFT -> FLASH next cycle, car 0100 for 4 cycles then 0000 for 4, walker 00. i_flash=0 -> CLEAR for 14 cycles, then GREEN.
- reset_n pulled low asynchronously mid-YEL1 -> outputs 0000/00, o_phase=0 without waiting for a clock edge. After release with i_start=1 -> GREEN with o_remain=19.
- i_start dropped during WALK -> IDLE at the next edge, outputs dark, ped_pending cleared. i_start reasserted -> full 20-cycle green.
